recovery_pin_conditioner: RTL and testbench
===========================================

Name: recovery_pin_conditioner

Overview:
Upstream neighbour of the clock recovery stage. Takes raw asynchronous recovery pins, synchronizes them into the system domain, and removes glitches with a per-line qualification counter. Emits the clean, pre-synchronized pin pair (clks_alot_p::recovery_pins_s) consumed as io_clk_i by recovery, plus single-cycle edge events and a glitch statistic.

Parameters:
SYNC_STAGES, 2, flops in each synchronizer chain; minimum 2.
FILTER_WIDTH, 4, width of the qualification counter and of filter_threshold_i.

Ports:
sys_dom_i  input  common_p::clk_dom_s  system clock domain; clk = posedge clock, rst = asynchronous, active-high reset
conditioner_en_i  input  1  enables filtering and event generation
raw_primary_i  input  1  asynchronous primary pin
raw_secondary_i  input  1  asynchronous secondary pin
invert_primary_i  input  1  invert primary after sync (quasi-static)
invert_secondary_i  input  1  invert secondary after sync (quasi-static)
filter_threshold_i  input  FILTER_WIDTH  consecutive cycles a new level must hold before acceptance
glitch_count_clear_i  input  1  synchronous clear of glitch_count_o
io_clk_o  output  clks_alot_p::recovery_pins_s  filtered pair; members primary, secondary
primary_rise_o / primary_fall_o  output  1 each  one-cycle pulses on filtered primary edges
secondary_rise_o / secondary_fall_o  output  1 each  one-cycle pulses on filtered secondary edges
stable_o  output  1  enabled, primed, both qualification counters at zero
glitch_count_o  output  16  saturating count of rejected transitions

Behaviour:
- Reset (async assert, sync release): sync chains, filtered levels, counters, priming flag = 0; all outputs 0.
- Sync chains run every cycle regardless of enable; inversion applied at the chain output (synced value s).
- Per line, filtered level f and counter c:
  - s == f: c <= 0; if c != 0 this cycle, record one glitch.
  - s != f and c + 1 >= threshold: f <= s, c <= 0, fire the matching rise/fall pulse in the cycle f changes.
  - s != f otherwise: c <= c + 1 (never wraps; bounded by threshold).
  - threshold 0 or 1: f follows s with one register of delay; no glitch possible.
- Latency, raw pin to io_clk_o: SYNC_STAGES + max(threshold,1) cycles.
- Threshold changes mid-qualification take effect immediately; if c already >= new threshold, accept next cycle.
- Disable (conditioner_en_i = 0): f holds, c <= 0, edge pulses suppressed, no glitches recorded, priming flag cleared, stable_o = 0.
- Enable rising: one priming cycle loads f <= s for both lines without edge pulses or glitch counting; normal operation next cycle.
- Glitch counter: +1 or +2 per cycle (both lines glitch together = +2); saturates at 16'hFFFF; clear has priority and drops any same-cycle increment.
- Reset mid-qualification: everything returns to reset values; no pulses on the release cycle.

Optional Feature:
CLKS_ALOT_GLITCH_COUNTER_EN: defined, glitch counter built as above. Undefined, counter logic omitted, glitch_count_o tied to 0, glitch_count_clear_i ignored; filtering unchanged.

Test Plan:
- Reset, enable, threshold=3; raw_primary 0->1 held -> io_clk_o.primary rises exactly SYNC_STAGES+3 cycles later, primary_rise_o high for 1 cycle, glitch_count_o=0.
- threshold=4; primary high pulse of 2 sys cycles -> io_clk_o.primary stays 0, no edge pulses, glitch_count_o=1.
- Both lines 2-cycle glitch in the same cycles -> glitch_count_o +2; force count to 16'hFFFE, repeat -> saturates at 16'hFFFF; clear asserted with a glitch -> 0.
- Disable, toggle primary to 1, re-enable -> io_clk_o.primary becomes 1 after priming cycle with no primary_rise_o; stable_o returns high the cycle after priming.
- invert_secondary_i=1, raw_secondary held 0, threshold=1 -> io_clk_o.secondary=1 after SYNC_STAGES+1 cycles with one secondary_rise_o.
- Assert rst while counter at 2 of 4 -> all outputs 0 immediately; after release with pins stable, no edge pulses.

Source files
------------

// File: rtl/recovery_pin_conditioner.sv
// Recovery pin conditioner: synchronizes the raw asynchronous recovery pins
// into the system domain and deglitches each line with a qualification
// counter. The output is the clean pin pair fed to clock recovery, plus
// one-cycle edge events and a saturating count of rejected transitions.
//
// Optional build macro: CLKS_ALOT_GLITCH_COUNTER_EN
//   defined   -> glitch counter built, glitch_count_clear_i honoured
//   undefined -> glitch_count_o tied to 0, glitch_count_clear_i ignored
//
// Ports:
//   sys_dom_i            system clock domain (clk posedge, rst async active-high)
//   conditioner_en_i     enables filtering and event generation
//   raw_primary_i        asynchronous primary pin
//   raw_secondary_i      asynchronous secondary pin
//   invert_primary_i     invert primary after synchronization (quasi-static)
//   invert_secondary_i   invert secondary after synchronization (quasi-static)
//   filter_threshold_i   cycles a new level must hold before it is accepted
//   glitch_count_clear_i synchronous clear of glitch_count_o
//   io_clk_o             filtered pin pair (primary, secondary)
//   primary_rise_o/primary_fall_o       one-cycle filtered primary edges
//   secondary_rise_o/secondary_fall_o   one-cycle filtered secondary edges
//   stable_o             enabled, primed and both counters idle
//   glitch_count_o       saturating count of rejected transitions

package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    typedef struct packed {
        logic primary;
        logic secondary;
    } recovery_pins_s;
endpackage

module recovery_pin_conditioner #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FILTER_WIDTH = 4
) (
    input  common_p::clk_dom_s          sys_dom_i,
    input  logic                        conditioner_en_i,
    input  logic                        raw_primary_i,
    input  logic                        raw_secondary_i,
    input  logic                        invert_primary_i,
    input  logic                        invert_secondary_i,
    input  logic [FILTER_WIDTH-1:0]     filter_threshold_i,
    input  logic                        glitch_count_clear_i,
    output clks_alot_p::recovery_pins_s io_clk_o,
    output logic                        primary_rise_o,
    output logic                        primary_fall_o,
    output logic                        secondary_rise_o,
    output logic                        secondary_fall_o,
    output logic                        stable_o,
    output logic [15:0]                 glitch_count_o
);

    localparam int unsigned NUM_LINES = 2;
    localparam int unsigned CNT_W     = FILTER_WIDTH + 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    logic clk;
    logic rst;
    assign clk = sys_dom_i.clk;
    assign rst = sys_dom_i.rst;

    // Line index 0 = primary, 1 = secondary
    logic [NUM_LINES-1:0]    raw;
    logic [NUM_LINES-1:0]    inv;
    logic [NUM_LINES-1:0]    s;
    logic [SYNC_STAGES-1:0]  sync_q [NUM_LINES];

    logic [NUM_LINES-1:0]    f_q;
    logic [NUM_LINES-1:0]    f_n;
    logic [FILTER_WIDTH-1:0] c_q    [NUM_LINES];
    logic [FILTER_WIDTH-1:0] c_n    [NUM_LINES];
    logic [CNT_W-1:0]        c_inc  [NUM_LINES];
    logic [CNT_W-1:0]        thr_ext;
    logic [NUM_LINES-1:0]    rise_q;
    logic [NUM_LINES-1:0]    rise_n;
    logic [NUM_LINES-1:0]    fall_q;
    logic [NUM_LINES-1:0]    fall_n;
    logic [NUM_LINES-1:0]    glitch_n;
    logic                    primed_q;
    logic                    primed_n;
    logic                    stable_q;
    logic                    stable_n;

    assign raw = {raw_secondary_i, raw_primary_i};
    assign inv = {invert_secondary_i, invert_primary_i};

    // Synchronizer chains run every cycle, independent of enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
        end
    end

    // Inversion sits after the chain so it never disturbs synchronization
    always_comb begin
        s = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1] ^ inv[i];
        end
    end

    assign thr_ext = CNT_W'(filter_threshold_i);

    // Per-line qualification: a new level must persist before it is accepted.
    // Comparing c+1 against the live threshold makes thresholds 0 and 1
    // equivalent and lets a lowered threshold accept on the next cycle.
    always_comb begin
        f_n      = f_q;
        rise_n   = '0;
        fall_n   = '0;
        glitch_n = '0;
        primed_n = conditioner_en_i;
        for (int i = 0; i < NUM_LINES; i++) begin
            c_n[i]   = '0;
            c_inc[i] = CNT_W'(c_q[i]) + CNT_W'(1);
            if (!conditioner_en_i) begin
                // hold level, drop any partial qualification
            end else if (!primed_q) begin
                // priming: adopt the current level silently
                f_n[i] = s[i];
            end else if (s[i] == f_q[i]) begin
                glitch_n[i] = (c_q[i] != '0);
            end else if (c_inc[i] >= thr_ext) begin
                f_n[i]    = s[i];
                rise_n[i] = s[i];
                fall_n[i] = ~s[i];
            end else begin
                c_n[i] = c_inc[i][FILTER_WIDTH-1:0];
            end
        end
        stable_n = conditioner_en_i && (c_n[0] == '0) && (c_n[1] == '0);
    end

    // Filter state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q      <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            primed_q <= 1'b0;
            stable_q <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            f_q      <= f_n;
            rise_q   <= rise_n;
            fall_q   <= fall_n;
            primed_q <= primed_n;
            stable_q <= stable_n;
            for (int i = 0; i < NUM_LINES; i++) begin
                c_q[i] <= c_n[i];
            end
        end
    end

`ifdef CLKS_ALOT_GLITCH_COUNTER_EN
    logic [15:0] gcnt_q;
    logic [15:0] gcnt_n;
    logic [16:0] gsum;

    // Both lines may reject in the same cycle; clear wins over increment
    always_comb begin
        gsum   = 17'(gcnt_q) + 17'(glitch_n[0]) + 17'(glitch_n[1]);
        gcnt_n = gcnt_q;
        if (glitch_count_clear_i) begin
            gcnt_n = '0;
        end else if (gsum[16]) begin
            gcnt_n = 16'hFFFF;
        end else begin
            gcnt_n = gsum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_n;
        end
    end

    assign glitch_count_o = gcnt_q;
`else
    logic unused_glitch;
    assign unused_glitch  = ^{glitch_count_clear_i, glitch_n};
    assign glitch_count_o = '0;
`endif

    assign io_clk_o.primary   = f_q[0];
    assign io_clk_o.secondary = f_q[1];
    assign primary_rise_o     = rise_q[0];
    assign primary_fall_o     = fall_q[0];
    assign secondary_rise_o   = rise_q[1];
    assign secondary_fall_o   = fall_q[1];
    assign stable_o           = stable_q;

endmodule

// File: tb/tb_recovery_pin_conditioner.sv
// Self-checking bench for recovery_pin_conditioner: directed scenarios
// followed by randomized pin activity, every cycle compared against a
// behavioural reference model.
module tb_recovery_pin_conditioner;

    localparam int unsigned S  = 2;
    localparam int unsigned FW = 4;
`ifdef CLKS_ALOT_GLITCH_COUNTER_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    common_p::clk_dom_s sys_dom;
    logic en, raw_p, raw_s, inv_p, inv_s, clr;
    logic [FW-1:0] thr;
    clks_alot_p::recovery_pins_s io_clk;
    logic p_rise, p_fall, s_rise, s_fall, stable;
    logic [15:0] gcount;

    int checks   = 0;
    int failures = 0;

    assign sys_dom.clk = clk;
    assign sys_dom.rst = rst;

    recovery_pin_conditioner #(
        .SYNC_STAGES (S),
        .FILTER_WIDTH(FW)
    ) dut (
        .sys_dom_i           (sys_dom),
        .conditioner_en_i    (en),
        .raw_primary_i       (raw_p),
        .raw_secondary_i     (raw_s),
        .invert_primary_i    (inv_p),
        .invert_secondary_i  (inv_s),
        .filter_threshold_i  (thr),
        .glitch_count_clear_i(clr),
        .io_clk_o            (io_clk),
        .primary_rise_o      (p_rise),
        .primary_fall_o      (p_fall),
        .secondary_rise_o    (s_rise),
        .secondary_fall_o    (s_fall),
        .stable_o            (stable),
        .glitch_count_o      (gcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit         m_f     [2];
    int         m_c     [2];
    bit         m_rise  [2];
    bit         m_fall  [2];
    bit         m_primed;
    bit         m_stable;
    int         m_gcnt;
    logic [1:0] m_hist  [$];   // raw samples, newest first

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_f[i] = 0; m_c[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        end
        m_primed = 0;
        m_stable = 0;
        m_gcnt   = 0;
        m_hist   = {};
        for (int i = 0; i < int'(S); i++) m_hist.push_back(2'b00);
    endtask

    // One clock edge of the specified behaviour
    task automatic model_edge();
        logic [1:0] sv;
        int g;
        if (rst) begin
            model_reset();
            return;
        end
        sv = m_hist[S-1] ^ {inv_s, inv_p};
        g  = 0;
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (!en) begin
                m_c[i] = 0;
            end else if (!m_primed) begin
                m_f[i] = sv[i];
                m_c[i] = 0;
            end else if (sv[i] == m_f[i]) begin
                if (m_c[i] != 0) g++;
                m_c[i] = 0;
            end else if (m_c[i] + 1 >= int'(thr)) begin
                m_f[i]    = sv[i];
                m_rise[i] = sv[i];
                m_fall[i] = !sv[i];
                m_c[i]    = 0;
            end else begin
                m_c[i]++;
            end
        end
        m_primed = en;
        m_stable = en && m_c[0] == 0 && m_c[1] == 0;
        if (clr) m_gcnt = 0;
        else if (m_gcnt + g > 65535) m_gcnt = 65535;
        else m_gcnt = m_gcnt + g;
        m_hist.push_front({raw_s, raw_p});
        void'(m_hist.pop_back());
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("io_clk.primary",   32'(io_clk.primary),   32'(m_f[0]));
        chk("io_clk.secondary", 32'(io_clk.secondary), 32'(m_f[1]));
        chk("primary_rise",     32'(p_rise),           32'(m_rise[0]));
        chk("primary_fall",     32'(p_fall),           32'(m_fall[0]));
        chk("secondary_rise",   32'(s_rise),           32'(m_rise[1]));
        chk("secondary_fall",   32'(s_fall),           32'(m_fall[1]));
        chk("stable",           32'(stable),           32'(m_stable));
        chk("glitch_count",     32'(gcount),           GC_EN ? 32'(m_gcnt) : 32'd0);
    endtask

    // Advance one clock, update the model, check 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int  n;
    bit  got;
    bit  saw;
    int  rise_cnt;
    logic rise_at;

    initial begin
        en = 0; raw_p = 0; raw_s = 0; inv_p = 0; inv_s = 0; clr = 0; thr = '0;
        rst = 1;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        rst = 0;

        // Clean primary edge with threshold 3
        thr = FW'(3);
        en  = 1;
        repeat (4) step();
        chk("stable_after_prime", 32'(stable), 32'd1);
        raw_p = 1;
        got = 0; n = 0; rise_at = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            step();
            if (io_clk.primary) begin
                got = 1; n = k; rise_at = p_rise;
            end
        end
        chk("latency_thr3", 32'(n), 32'(S + 3));
        chk("rise_at_accept", 32'(rise_at), 32'd1);
        step();
        chk("rise_one_cycle", 32'(p_rise), 32'd0);
        chk("gcount_clean_edge", 32'(gcount), 32'd0);

        // Two-cycle high pulse rejected with threshold 4
        raw_p = 0;
        repeat (8) step();
        thr = FW'(4);
        saw = 0;
        raw_p = 1;
        repeat (2) begin step(); saw |= io_clk.primary | p_rise | p_fall; end
        raw_p = 0;
        repeat (10) begin step(); saw |= io_clk.primary | p_rise | p_fall; end
        chk("glitch_no_edge", 32'(saw), 32'd0);
        chk("gcount_single", 32'(gcount), GC_EN ? 32'd1 : 32'd0);

        // Both lines glitch together
        raw_p = 1; raw_s = 1;
        repeat (2) step();
        raw_p = 0; raw_s = 0;
        repeat (8) step();
        chk("gcount_double", 32'(gcount), GC_EN ? 32'd3 : 32'd0);

        // Primary-only glitch to reach an even count
        raw_p = 1;
        repeat (2) step();
        raw_p = 0;
        repeat (8) step();
        chk("gcount_even", 32'(gcount), GC_EN ? 32'd4 : 32'd0);

`ifdef CLKS_ALOT_GLITCH_COUNTER_EN
        // Drive double glitches until the counter saturates (passes 16'hFFFE)
        thr = FW'(2);
        for (int k = 0; k < 65600; k++) begin
            raw_p = ~raw_p;
            raw_s = raw_p;
            step();
        end
        raw_p = 0; raw_s = 0;
        repeat (6) step();
        chk("gcount_saturated", 32'(gcount), 32'hFFFF);
`endif

        // Clear has priority over a same-cycle glitch
        thr = FW'(4);
        raw_p = 1; raw_s = 1;
        repeat (2) step();
        raw_p = 0; raw_s = 0;
        clr = 1;
        repeat (5) step();
        clr = 0;
        repeat (4) step();
        chk("gcount_cleared", 32'(gcount), 32'd0);

        // Disable, change level, re-enable: priming adopts level silently
        en = 0;
        raw_p = 1;
        repeat (6) step();
        chk("disabled_hold", 32'(io_clk.primary), 32'd0);
        chk("disabled_stable", 32'(stable), 32'd0);
        en = 1;
        step();
        chk("prime_loads_level", 32'(io_clk.primary), 32'd1);
        chk("prime_no_rise", 32'(p_rise), 32'd0);
        chk("stable_after_prime2", 32'(stable), 32'd1);
        raw_p = 0;
        repeat (8) step();

        // Inverted secondary with threshold 1
        thr = FW'(1);
        raw_s = 1; inv_s = 1;
        repeat (8) step();
        raw_s = 0;
        got = 0; n = 0; rise_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (s_rise) rise_cnt++;
            if (io_clk.secondary && !got) begin got = 1; n = k; end
        end
        chk("latency_inv_thr1", 32'(n), 32'(S + 1));
        chk("inv_rise_count", 32'(rise_cnt), 32'd1);

        // Reset in the middle of a qualification (counter at 2 of 4)
        thr = FW'(4);
        raw_p = 1;
        repeat (S + 2) step();
        rst = 1; inv_s = 0; raw_s = 0; raw_p = 0;
        model_reset();
        #1;
        chk("rst_primary",   32'(io_clk.primary),   32'd0);
        chk("rst_secondary", 32'(io_clk.secondary), 32'd0);
        chk("rst_edges",     32'({p_rise, p_fall, s_rise, s_fall}), 32'd0);
        chk("rst_stable",    32'(stable), 32'd0);
        chk("rst_gcount",    32'(gcount), 32'd0);
        repeat (2) step();
        rst = 0;
        saw = 0;
        repeat (12) begin step(); saw |= p_rise | p_fall | s_rise | s_fall; end
        chk("no_pulse_after_reset", 32'(saw), 32'd0);

        // Randomized activity against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0)   raw_p = ~raw_p;
            if ($urandom_range(0, 3) == 0)   raw_s = ~raw_s;
            if ($urandom_range(0, 49) == 0)  thr   = FW'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0)  en    = ~en;
            if ($urandom_range(0, 199) == 0) inv_p = ~inv_p;
            if ($urandom_range(0, 199) == 0) inv_s = ~inv_s;
            clr = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
